// File: rtl/fpga_slow_clk_mon_pkg.sv
// Shared types and helpers for the slow-clock frequency/lock monitor.
// Optional irq output is enabled by FPGA_SLOW_CLK_MON_IRQ_EN.
package fpga_slow_clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        ACQUIRE,
        LOCKED
    } mon_state_e;

    // Lower bound clamps at zero so a large tolerance cannot wrap.
    function automatic logic in_tol(
        input logic [31:0] period,
        input logic [31:0] expected,
        input logic [31:0] tol
    );
        logic [31:0] lo;
        lo = (expected > tol) ? expected - tol : '0;
        return (period >= lo) && (period <= expected + tol);
    endfunction

endpackage

// File: rtl/fpga_slow_clk_monitor_if.sv
// Control/status bundle of the slow-clock monitor.
// irq_o exists only when FPGA_SLOW_CLK_MON_IRQ_EN is defined.
interface fpga_slow_clk_monitor_if #(
    parameter int CNT_W = 9
);
    logic             enable_i;
    logic             clear_err_i;
    logic [CNT_W-1:0] period_o;
    logic             period_valid_o;
    logic             locked_o;
    logic             err_o;
`ifdef FPGA_SLOW_CLK_MON_IRQ_EN
    logic             irq_o;

    modport master (
        output enable_i, clear_err_i,
        input  period_o, period_valid_o, locked_o, err_o, irq_o
    );
    modport slave (
        input  enable_i, clear_err_i,
        output period_o, period_valid_o, locked_o, err_o, irq_o
    );
`else
    modport master (
        output enable_i, clear_err_i,
        input  period_o, period_valid_o, locked_o, err_o
    );
    modport slave (
        input  enable_i, clear_err_i,
        output period_o, period_valid_o, locked_o, err_o
    );
`endif
endinterface

// File: rtl/fpga_slow_clk_edge_det.sv
// Synchronizer chain plus history flop; flags one cycle per rising edge.
// No configuration macros.
module fpga_slow_clk_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic din,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/fpga_slow_clk_monitor.sv
// Measures slow_clk_i periods in fast cycles, tracks lock, flags sticky errors.
// Define FPGA_SLOW_CLK_MON_IRQ_EN to add a per-event irq_o pulse.
module fpga_slow_clk_monitor
    import fpga_slow_clk_mon_pkg::*;
#(
    parameter int EXP_PERIOD  = 256,
    parameter int TOLERANCE   = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic intermmediate_clock,
    input  logic rst_ni,
    input  logic slow_clk_i,
    fpga_slow_clk_monitor_if.slave mon
);

    localparam int MAX_CNT = EXP_PERIOD + TOLERANCE;
    localparam int CNT_W   = $clog2(EXP_PERIOD + TOLERANCE + 2);
    localparam int GC_W    = $clog2(LOCK_COUNT + 1);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] meas;
    logic [GC_W-1:0]  good_q, good_d, good_inc;
    logic             gap_q, gap_d;
    logic             valid_q, valid_d;
    logic             locked_q, err_q, err_set;
    logic             rise, timeout, good, at_max;

    fpga_slow_clk_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk   (intermmediate_clock),
        .rst_ni(rst_ni),
        .din   (slow_clk_i),
        .rise_o(rise)
    );

    assign meas     = cnt_q + 1'b1;
    assign at_max   = (cnt_q == CNT_W'(MAX_CNT));
    assign good     = in_tol(32'(meas), 32'(EXP_PERIOD), 32'(TOLERANCE));
    assign timeout  = at_max && !rise && !gap_q;
    assign good_inc = good_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        period_d = period_q;
        valid_d  = 1'b0;
        err_set  = 1'b0;
        cnt_d    = rise ? '0 : (at_max ? cnt_q : cnt_q + 1'b1);
        gap_d    = rise ? 1'b0 : (timeout | gap_q);
        if (!mon.enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            good_d  = '0;
            gap_d   = 1'b0;
        end else begin
            if (rise && (state_q == ACQUIRE || state_q == LOCKED)) begin
                period_d = meas;
                valid_d  = 1'b1;
            end
            unique case (state_q)
                IDLE: state_d = WAIT_FIRST;
                WAIT_FIRST: begin
                    if (rise) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end
                ACQUIRE: begin
                    if (rise) begin
                        good_d = good ? good_inc : '0;
                        if (good && good_inc == GC_W'(LOCK_COUNT))
                            state_d = LOCKED;
                    end else if (timeout) begin
                        state_d = WAIT_FIRST;
                    end
                end
                LOCKED: begin
                    if (rise && !good) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                        err_set = 1'b1;
                    end else if (timeout) begin
                        state_d = WAIT_FIRST;
                        err_set = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge intermmediate_clock or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            good_q   <= '0;
            gap_q    <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            gap_q    <= gap_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            locked_q <= (state_d == LOCKED);
            // A new error event beats a simultaneous clear.
            err_q    <= err_set | (err_q & ~mon.clear_err_i);
        end
    end

    assign mon.period_o       = period_q;
    assign mon.period_valid_o = valid_q;
    assign mon.locked_o       = locked_q;
    assign mon.err_o          = err_q;

`ifdef FPGA_SLOW_CLK_MON_IRQ_EN
    logic irq_q;

    always_ff @(posedge intermmediate_clock or negedge rst_ni) begin
        if (!rst_ni) irq_q <= 1'b0;
        else         irq_q <= err_set;
    end

    assign mon.irq_o = irq_q;
`endif

endmodule

// File: tb/tb_fpga_slow_clk_monitor.sv
// Bench for fpga_slow_clk_monitor: directed scenarios plus random periods vs. a behavioural model.
// Honors FPGA_SLOW_CLK_MON_IRQ_EN to also check irq_o.
`timescale 1ns/1ps
module tb_fpga_slow_clk_monitor;

    localparam int EXP  = 256;
    localparam int TOL  = 2;
    localparam int LCK  = 4;
    localparam int S    = 2;
    localparam int CW   = 9;
    localparam int MAXC = EXP + TOL;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    logic slow   = 1'b0;

    always #5 clk = ~clk;

    fpga_slow_clk_monitor_if #(.CNT_W(CW)) mon();

    fpga_slow_clk_monitor dut (
        .intermmediate_clock(clk),
        .rst_ni             (rst_ni),
        .slow_clk_i         (slow),
        .mon                (mon)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: slow-clock history, elapsed time and lock progress.
    bit past[0:S];
    int since;
    bit gap_seen;
    bit active, primed, locked;
    int run;
    int e_period;
    bit e_valid, e_err, e_irq;

    task automatic model_reset();
        for (int j = 0; j <= S; j++) past[j] = 1'b0;
        since = 0; gap_seen = 0;
        active = 0; primed = 0; locked = 0; run = 0;
        e_period = 0; e_valid = 0; e_err = 0; e_irq = 0;
    endtask

    task automatic model_step(input bit en, input bit clr, input bit v);
        bit rise, tmo, ok, evt;
        int per;
        rise = past[S-1] && !past[S];
        for (int j = S; j > 0; j--) past[j] = past[j-1];
        past[0] = v;
        per = since + 1;
        ok  = (per >= EXP - TOL) && (per <= EXP + TOL);
        tmo = (since == MAXC) && !rise && !gap_seen;
        e_valid = 0;
        evt = 0;
        if (!en) begin
            active = 0; primed = 0; locked = 0; run = 0;
            since = 0; gap_seen = 0;
        end else begin
            if (rise && primed) begin
                e_period = per;
                e_valid  = 1;
            end
            if (!active) begin
                active = 1;
            end else if (!primed) begin
                if (rise) begin primed = 1; run = 0; end
            end else if (!locked) begin
                if (rise) begin
                    if (ok) begin
                        run++;
                        if (run == LCK) locked = 1;
                    end else run = 0;
                end else if (tmo) primed = 0;
            end else begin
                if (rise && !ok) begin
                    locked = 0; run = 0; evt = 1;
                end else if (tmo) begin
                    locked = 0; primed = 0; evt = 1;
                end
            end
            since    = rise ? 0 : (since == MAXC ? MAXC : since + 1);
            gap_seen = rise ? 0 : (tmo | gap_seen);
        end
        if (evt) e_err = 1;
        else if (clr) e_err = 0;
        e_irq = evt;
    endtask

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) model_reset();
        else model_step(mon.enable_i, mon.clear_err_i, slow);
    end

    always @(posedge clk) begin
        #1;
        chk("m_period", mon.period_o, e_period);
        chk("m_valid", mon.period_valid_o, e_valid);
        chk("m_locked", mon.locked_o, locked);
        chk("m_err", mon.err_o, e_err);
`ifdef FPGA_SLOW_CLK_MON_IRQ_EN
        chk("m_irq", mon.irq_o, e_irq);
`endif
    end

    task automatic drive(input bit v, input int n, input int clr_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            slow = v;
            mon.clear_err_i = (i == clr_at);
        end
    endtask

    task automatic period(input int p);
        drive(1'b1, p / 2, -1);
        drive(1'b0, p - p / 2, -1);
    endtask

    task automatic finish_256();
        drive(1'b1, 128 - (S + 2), -1);
        drive(1'b0, 128, -1);
    endtask

    initial begin
        mon.enable_i    = 1'b0;
        mon.clear_err_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", mon.period_o, 0);
        chk("rst_valid", mon.period_valid_o, 0);
        chk("rst_locked", mon.locked_o, 0);
        chk("rst_err", mon.err_o, 0);
        rst_ni = 1'b1;
        mon.enable_i = 1'b1;

        // First rise discarded, lock on the 4th good period.
        repeat (4) period(256);
        drive(1'b1, S + 1, -1);
        chk("t1_prelock", mon.locked_o, 0);
        drive(1'b1, 1, -1);
        chk("t1_locked", mon.locked_o, 1);
        chk("t1_valid", mon.period_valid_o, 1);
        chk("t1_period", mon.period_o, 256);
        chk("t1_err", mon.err_o, 0);
        drive(1'b1, 128 - (S + 2), -1);
        drive(1'b0, 128, -1);

        // One long period while locked.
        period(259);
        drive(1'b1, S + 2, -1);
        chk("t2_period", mon.period_o, 259);
        chk("t2_locked", mon.locked_o, 0);
        chk("t2_err", mon.err_o, 1);
        finish_256();
        repeat (3) period(256);
        drive(1'b1, S + 2, -1);
        chk("t2_relock", mon.locked_o, 1);
        finish_256();

        // Clear alone, then a missing edge while locked.
        drive(1'b0, 2, 0);
        chk("t5_clear", mon.err_o, 0);
        drive(1'b0, 300, -1);
        chk("t3_locked", mon.locked_o, 0);
        chk("t3_err", mon.err_o, 1);
        chk("t3_valid", mon.period_valid_o, 0);
        repeat (4) period(256);
        drive(1'b1, S + 2, -1);
        chk("t3_relock", mon.locked_o, 1);
        finish_256();

        // Tolerance edges 254/258 all good.
        drive(1'b0, 2, 0);
        repeat (3) begin
            period(254);
            period(258);
        end
        chk("t4_locked", mon.locked_o, 1);
        chk("t4_err", mon.err_o, 0);

        // Disable, then a 253 while acquiring.
        @(negedge clk);
        mon.enable_i = 1'b0;
        @(negedge clk);
        chk("t6_dis_locked", mon.locked_o, 0);
        mon.enable_i = 1'b1;
        repeat (2) period(256);
        period(253);
        drive(1'b1, S + 2, -1);
        chk("t4_p253", mon.period_o, 253);
        chk("t4_err253", mon.err_o, 0);
        finish_256();
        repeat (2) period(256);
        drive(1'b1, S + 2, -1);
        chk("t4_nolock", mon.locked_o, 0);
        finish_256();

        // Set beats clear in the same cycle.
        period(256);
        period(250);
        drive(1'b1, S + 2, S);
        chk("t5_setwins", mon.err_o, 1);
        chk("t5_p250", mon.period_o, 250);
        finish_256();
        drive(1'b0, 2, 0);
        chk("t5_clear2", mon.err_o, 0);

        // Disable mid-acquire, then async reset mid-period.
        period(256);
        drive(1'b1, 10, -1);
        @(negedge clk);
        mon.enable_i = 1'b0;
        @(negedge clk);
        chk("t6_locked", mon.locked_o, 0);
        chk("t6_valid", mon.period_valid_o, 0);
        chk("t6_keep", mon.period_o, 256);
        mon.enable_i = 1'b1;
        drive(1'b0, 5, -1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rst_period", mon.period_o, 0);
        chk("t6_rst_err", mon.err_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Random periods, gaps, clears and enable drops.
        for (int it = 0; it < 70; it++) begin
            int r, p, h;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                drive(1'b0, $urandom_range(260, 400), -1);
            end else if (r == 1) begin
                @(negedge clk);
                mon.enable_i = 1'b0;
                drive(slow, $urandom_range(1, 5), -1);
                mon.enable_i = 1'b1;
            end else begin
                p = (r < 12) ? $urandom_range(254, 258) : $urandom_range(250, 262);
                h = $urandom_range(2, p - 2);
                drive(1'b1, h, (r % 5 == 0) ? $urandom_range(0, h - 1) : -1);
                drive(1'b0, p - h, -1);
            end
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
